// File: rtl/nrf_spi_sequencer.sv
// SPI transaction engine for the nRF24L01+: CSN framing, mode-0 SCK, byte streaming,
// CE pulse generation and synchronised IRQ falling-edge capture.
module nrf_spi_sequencer #(
  parameter int unsigned CLK_DIV         = 4,
  parameter int unsigned CE_PULSE_CYCLES = 500
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic [5:0] cmd_len,
  output logic       tx_rd,
  input  logic [7:0] tx_data,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic [7:0] status,
  output logic       done,
  input  logic       ce_hold,
  input  logic       ce_pulse,
  input  logic       irq_clr,
  output logic       irq_flag,
  output logic       nrf_ce,
  output logic       nrf_csn,
  output logic       nrf_sck,
  output logic       nrf_mosi,
  input  logic       nrf_miso,
  input  logic       nrf_irq
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CS_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT    = 3'd2;
  localparam logic [2:0] S_CS_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;

  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned GAP_CYC = 2 * CLK_DIV + 2;
  localparam int unsigned GAP_W   = $clog2(GAP_CYC);
  localparam int unsigned CE_W    = $clog2(CE_PULSE_CYCLES + 1);

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [3:0]       half_q, half_d;
  logic [5:0]       byte_q, byte_d;
  logic [5:0]       len_q, len_d;
  logic [7:0]       sh_out_q, sh_out_d;
  logic [7:0]       sh_in_q, sh_in_d;
  logic             csn_q, csn_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             tx_rd_q, tx_rd_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic [7:0]       status_q, status_d;
  logic             done_q, done_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [CE_W-1:0]  ce_cnt_q, ce_cnt_d;
  logic             ce_q, ce_d;
  logic             irq_s1_q, irq_s2_q, irq_prev_q;
  logic             irq_flag_q, irq_flag_d;
  logic             tick;
  logic             irq_fall;

  assign tick     = (state_q != S_IDLE) && (div_q == DIV_W'(CLK_DIV - 1));
  // Synchroniser stages reset low, so a line already low at reset release never looks like a fall.
  assign irq_fall = irq_prev_q && !irq_s2_q;

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    half_d      = half_q;
    byte_d      = byte_q;
    len_d       = len_q;
    sh_out_d    = sh_out_q;
    sh_in_d     = sh_in_q;
    csn_d       = csn_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    rx_data_d   = rx_data_q;
    status_d    = status_q;
    tx_rd_d     = 1'b0;
    rx_valid_d  = 1'b0;
    done_d      = 1'b0;
    div_d       = (state_q == S_IDLE || tick) ? '0 : div_q + DIV_W'(1);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d  = S_CS_SETUP;
          csn_d    = 1'b0;
          sh_out_d = cmd_byte;
          mosi_d   = cmd_byte[7];
          len_d    = (cmd_len > 6'd32) ? 6'd32 : cmd_len;
          byte_d   = '0;
          half_d   = '0;
          sh_in_d  = '0;
        end
      end
      S_CS_SETUP: begin
        if (tick) begin
          sck_d   = 1'b1;
          sh_in_d = {sh_in_q[6:0], nrf_miso};
          half_d  = 4'd1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          if (!sck_q) begin
            sck_d   = 1'b1;
            sh_in_d = {sh_in_q[6:0], nrf_miso};
            half_d  = half_q + 4'd1;
          end else begin
            sck_d = 1'b0;
            if (half_q == 4'd15) begin
              if (byte_q == '0) begin
                status_d = sh_in_q;
              end else begin
                rx_data_d  = sh_in_q;
                rx_valid_d = 1'b1;
              end
              half_d = '0;
              // Next payload byte is fetched on the last falling edge so SCK never pauses.
              if (byte_q != len_q) begin
                byte_d   = byte_q + 6'd1;
                sh_out_d = tx_data;
                mosi_d   = tx_data[7];
                tx_rd_d  = 1'b1;
              end else begin
                mosi_d  = 1'b0;
                state_d = S_CS_HOLD;
              end
            end else begin
              sh_out_d = {sh_out_q[6:0], 1'b0};
              mosi_d   = sh_out_q[6];
              half_d   = half_q + 4'd1;
            end
          end
        end
      end
      S_CS_HOLD: begin
        // First tick completes the last bit's low phase, second is the CSN hold time.
        if (tick) begin
          if (half_q == '0) begin
            half_d = 4'd1;
          end else begin
            csn_d   = 1'b1;
            done_d  = 1'b1;
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);

    if (ce_pulse) begin
      ce_cnt_d = CE_W'(CE_PULSE_CYCLES);
    end else if (ce_cnt_q != '0) begin
      ce_cnt_d = ce_cnt_q - CE_W'(1);
    end else begin
      ce_cnt_d = ce_cnt_q;
    end
    ce_d = ce_hold || (ce_cnt_d != '0);

    if (irq_fall) begin
      irq_flag_d = 1'b1;
    end else if (irq_clr) begin
      irq_flag_d = 1'b0;
    end else begin
      irq_flag_d = irq_flag_q;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      gap_q       <= '0;
      half_q      <= '0;
      byte_q      <= '0;
      len_q       <= '0;
      sh_out_q    <= '0;
      sh_in_q     <= '0;
      csn_q       <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      tx_rd_q     <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      status_q    <= '0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      ce_cnt_q    <= '0;
      ce_q        <= 1'b0;
      irq_s1_q    <= 1'b0;
      irq_s2_q    <= 1'b0;
      irq_prev_q  <= 1'b0;
      irq_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      gap_q       <= gap_d;
      half_q      <= half_d;
      byte_q      <= byte_d;
      len_q       <= len_d;
      sh_out_q    <= sh_out_d;
      sh_in_q     <= sh_in_d;
      csn_q       <= csn_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      tx_rd_q     <= tx_rd_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      status_q    <= status_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
      ce_cnt_q    <= ce_cnt_d;
      ce_q        <= ce_d;
      irq_s1_q    <= nrf_irq;
      irq_s2_q    <= irq_s1_q;
      irq_prev_q  <= irq_s2_q;
      irq_flag_q  <= irq_flag_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign tx_rd     = tx_rd_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign status    = status_q;
  assign done      = done_q;
  assign irq_flag  = irq_flag_q;
  assign nrf_ce    = ce_q;
  assign nrf_csn   = csn_q;
  assign nrf_sck   = sck_q;
  assign nrf_mosi  = mosi_q;

endmodule
